// File: rtl/dp_sequencer.sv
// dp_sequencer: Moore controller for the 16-bit register/ALU/shifter datapath.
// Fetches into IR, decodes it, and strobes the datapath one state at a time.
module dp_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ir,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic [1:0]  mem_cmd,
    output logic        halted,
    output logic        bad_instr
);

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM,
        S_GET_A, S_GET_B, S_EXEC, S_WB, S_ADDR, S_LD_ADDR,
        S_MEM_RD, S_LDR_WB, S_ST_GETB, S_ST_PASS, S_MEM_WR, S_HALT
    } state_t;

    state_t        state;
    logic [CW-1:0] wcnt;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic [4:0] code;
    logic       wait_done, is_mem, is_ldr, is_cmp, is_movr;

    assign opcode    = ir[15:13];
    assign op        = ir[12:11];
    assign rn        = ir[10:8];
    assign rd        = ir[7:5];
    assign sh        = ir[4:3];
    assign rm        = ir[2:0];
    assign code      = {opcode, op};
    assign wait_done = (wcnt == WAIT_LAST);
    assign is_ldr    = (opcode == 3'b011);
    assign is_mem    = is_ldr || (opcode == 3'b100);
    assign is_cmp    = (code == 5'b10101);
    assign is_movr   = (code == 5'b11000);

    // State register, read wait counter and sticky undefined-opcode flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RST;
            wcnt      <= '0;
            bad_instr <= 1'b0;
        end else begin
            wcnt <= '0;
            case (state)
                S_RST:    state <= S_IF1;
                S_IF1: begin
                    if (wait_done) state <= S_IF2;
                    else           wcnt  <= wcnt + CW'(1);
                end
                S_IF2:    state <= S_UPD_PC;
                S_UPD_PC: state <= S_DECODE;
                S_DECODE: begin
                    case (code)
                        5'b11010: state <= S_WR_IMM;
                        5'b11000,
                        5'b10111: state <= S_GET_B;
                        5'b10100, 5'b10101, 5'b10110,
                        5'b01100, 5'b10000: state <= S_GET_A;
                        5'b11100: state <= S_HALT;
                        default: begin
                            state     <= S_HALT;
                            bad_instr <= 1'b1;
                        end
                    endcase
                end
                S_WR_IMM:  state <= S_IF1;
                S_GET_A:   state <= is_mem ? S_ADDR : S_GET_B;
                S_GET_B:   state <= S_EXEC;
                S_EXEC:    state <= is_cmp ? S_IF1 : S_WB;
                S_WB:      state <= S_IF1;
                S_ADDR:    state <= S_LD_ADDR;
                S_LD_ADDR: state <= is_ldr ? S_MEM_RD : S_ST_GETB;
                S_MEM_RD: begin
                    if (wait_done) state <= S_LDR_WB;
                    else           wcnt  <= wcnt + CW'(1);
                end
                S_LDR_WB:  state <= S_IF1;
                S_ST_GETB: state <= S_ST_PASS;
                S_ST_PASS: state <= S_MEM_WR;
                S_MEM_WR:  state <= S_IF1;
                S_HALT:    state <= S_HALT;
                default:   state <= S_RST;
            endcase
        end
    end

    // Moore decode of the current state into datapath strobes
    always_comb begin
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        ALUop     = 2'b00;
        loadc     = 1'b0;
        loads     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = 2'b00;
        halted    = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b01;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = 2'b01;
                load_ir  = 1'b1;
            end
            S_UPD_PC: load_pc = 1'b1;
            S_WR_IMM: begin
                writenum = rn;
                vsel     = 2'b01;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                asel  = is_movr;
                ALUop = is_movr ? 2'b00 : op;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            S_WB: begin
                writenum = rd;
                vsel     = 2'b11;
                write    = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD:  mem_cmd   = 2'b01;
            S_LDR_WB: begin
                mem_cmd  = 2'b01;
                writenum = rd;
                write    = 1'b1;
            end
            S_ST_GETB: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_ST_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_WR: mem_cmd = 2'b10;
            S_HALT:   halted  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed per-cycle control-word checks for dp_sequencer.
// Two instances run side by side: MEM_WAIT=0 and MEM_WAIT=2.
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] ir = 16'h0000;

    always #5 clk = ~clk;

    logic [2:0] rn_0, wn_0, rn_2, wn_2;
    logic [1:0] vs_0, sh_0, alu_0, mc_0, vs_2, sh_2, alu_2, mc_2;
    logic wr_0, la_0, lb_0, as_0, bs_0, lc_0, ls_0, lir_0, lpc_0;
    logic rpc_0, asl_0, ladr_0, h_0, bad_0;
    logic wr_2, la_2, lb_2, as_2, bs_2, lc_2, ls_2, lir_2, lpc_2;
    logic rpc_2, asl_2, ladr_2, h_2, bad_2;

    dp_sequencer #(.MEM_WAIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .ir(ir),
        .readnum(rn_0), .writenum(wn_0), .write(wr_0), .vsel(vs_0),
        .loada(la_0), .loadb(lb_0), .asel(as_0), .bsel(bs_0),
        .shift(sh_0), .ALUop(alu_0), .loadc(lc_0), .loads(ls_0),
        .load_ir(lir_0), .load_pc(lpc_0), .reset_pc(rpc_0),
        .addr_sel(asl_0), .load_addr(ladr_0), .mem_cmd(mc_0),
        .halted(h_0), .bad_instr(bad_0)
    );

    dp_sequencer #(.MEM_WAIT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .ir(ir),
        .readnum(rn_2), .writenum(wn_2), .write(wr_2), .vsel(vs_2),
        .loada(la_2), .loadb(lb_2), .asel(as_2), .bsel(bs_2),
        .shift(sh_2), .ALUop(alu_2), .loadc(lc_2), .loads(ls_2),
        .load_ir(lir_2), .load_pc(lpc_2), .reset_pc(rpc_2),
        .addr_sel(asl_2), .load_addr(ladr_2), .mem_cmd(mc_2),
        .halted(h_2), .bad_instr(bad_2)
    );

    logic [31:0] cw0, cw2;
    assign cw0 = {3'b0, rn_0, wn_0, wr_0, vs_0, la_0, lb_0, as_0, bs_0,
                  sh_0, alu_0, lc_0, ls_0, lir_0, lpc_0, rpc_0, asl_0,
                  ladr_0, mc_0, h_0, bad_0, 1'b0};
    assign cw2 = {3'b0, rn_2, wn_2, wr_2, vs_2, la_2, lb_2, as_2, bs_2,
                  sh_2, alu_2, lc_2, ls_2, lir_2, lpc_2, rpc_2, asl_2,
                  ladr_2, mc_2, h_2, bad_2, 1'b0};

    localparam logic [31:0] BAD_B  = 32'h1 << 1;
    localparam logic [31:0] H_B    = 32'h1 << 2;
    localparam logic [31:0] LADR_B = 32'h1 << 5;
    localparam logic [31:0] ASL_B  = 32'h1 << 6;
    localparam logic [31:0] RPC_B  = 32'h1 << 7;
    localparam logic [31:0] LPC_B  = 32'h1 << 8;
    localparam logic [31:0] LIR_B  = 32'h1 << 9;
    localparam logic [31:0] LS_B   = 32'h1 << 10;
    localparam logic [31:0] LC_B   = 32'h1 << 11;
    localparam logic [31:0] BS_B   = 32'h1 << 16;
    localparam logic [31:0] AS_B   = 32'h1 << 17;
    localparam logic [31:0] LB_B   = 32'h1 << 18;
    localparam logic [31:0] LA_B   = 32'h1 << 19;
    localparam logic [31:0] W_B    = 32'h1 << 22;

    function automatic logic [31:0] f_mc(input int x);
        return 32'(x) << 3;
    endfunction
    function automatic logic [31:0] f_alu(input int x);
        return 32'(x) << 12;
    endfunction
    function automatic logic [31:0] f_sh(input int x);
        return 32'(x) << 14;
    endfunction
    function automatic logic [31:0] f_vs(input int x);
        return 32'(x) << 20;
    endfunction
    function automatic logic [31:0] f_wn(input int x);
        return 32'(x) << 23;
    endfunction
    function automatic logic [31:0] f_rn(input int x);
        return 32'(x) << 26;
    endfunction

    localparam logic [31:0] RSTW = LPC_B | RPC_B;
    localparam logic [31:0] IF1W = ASL_B | (32'h1 << 3);
    localparam logic [31:0] IF2W = IF1W | LIR_B;
    localparam logic [31:0] UPDW = LPC_B;
    localparam logic [31:0] DECW = 32'h0;
    localparam logic [31:0] ADRW = BS_B | LC_B;
    localparam logic [31:0] LDAW = LADR_B;

    int errors = 0;
    int checks = 0;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances with ir held, leave time in the first IF1 cycle
    task automatic do_reset(input logic [15:0] v);
        @(negedge clk);
        reset_n = 1'b0;
        ir = v;
        #1;
        check("rst_dut0", cw0, RSTW);
        check("rst_dut2", cw2, RSTW);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release", cw0, RSTW);
        step();
    endtask

    // Walk the expected-word queue one cycle per entry
    task automatic run(input string nm, input bit sel2);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s.c%0d", nm, i), sel2 ? cw2 : cw0, q[i]);
            if (i != q.size() - 1) step();
        end
    endtask

    initial begin
        // MOV R3,#5
        do_reset(16'hD305);
        q = '{IF1W, IF2W, UPDW, DECW, f_wn(3) | f_vs(1) | W_B, IF1W};
        run("mov_imm", 1'b0);

        // ADD R2,R1,R0,LSL#1
        do_reset(16'hA148);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(1) | LA_B, f_rn(0) | LB_B,
              f_sh(1) | LC_B, f_wn(2) | f_vs(3) | W_B, IF1W};
        run("add", 1'b0);

        // CMP R1,R0
        do_reset(16'hA900);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(1) | LA_B, f_rn(0) | LB_B,
              LS_B | f_alu(1), IF1W};
        run("cmp", 1'b0);

        // MVN R1,R3,LSR#1
        do_reset(16'hB833);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(3) | LB_B,
              f_sh(2) | f_alu(3) | LC_B, f_wn(1) | f_vs(3) | W_B, IF1W};
        run("mvn", 1'b0);

        // MOV R2,R5
        do_reset(16'hC045);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(5) | LB_B, AS_B | LC_B,
              f_wn(2) | f_vs(3) | W_B, IF1W};
        run("mov_reg", 1'b0);

        // LDR R4,[R1,#2] with no wait states and with two
        do_reset(16'h6182);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(1) | LA_B, ADRW, LDAW,
              f_mc(1), f_mc(1) | f_wn(4) | W_B, IF1W};
        run("ldr_w0", 1'b0);
        do_reset(16'h6182);
        q = '{IF1W, IF1W, IF1W, IF2W, UPDW, DECW, f_rn(1) | LA_B, ADRW,
              LDAW, f_mc(1), f_mc(1), f_mc(1),
              f_mc(1) | f_wn(4) | W_B, IF1W};
        run("ldr_w2", 1'b1);

        // STR R4,[R1,#2]
        do_reset(16'h8182);
        q = '{IF1W, IF2W, UPDW, DECW, f_rn(1) | LA_B, ADRW, LDAW,
              f_rn(4) | LB_B, AS_B | LC_B, f_mc(2), IF1W};
        run("str", 1'b0);

        // Reset landing in the middle of ADD's EXEC cycle
        do_reset(16'hA148);
        repeat (6) step();
        check("abort_exec", cw0, f_sh(1) | LC_B);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_rst", cw0, RSTW);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_rst_cycle", cw0, RSTW);
        step();
        check("abort_if1", cw0, IF1W);

        // HALT
        do_reset(16'hE000);
        q = '{IF1W, IF2W, UPDW, DECW};
        run("halt_fetch", 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("halt.c%0d", i), cw0, H_B);
        end

        // Undefined opcode, then reset clears bad_instr
        do_reset(16'h0000);
        q = '{IF1W, IF2W, UPDW, DECW, H_B | BAD_B, H_B | BAD_B,
              H_B | BAD_B, H_B | BAD_B};
        run("undef", 1'b0);
        do_reset(16'hE000);
        check("undef_cleared", cw0, IF1W);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Moore FSM controller for the 16-bit register/ALU/shifter datapath.
- Fetches a 16-bit instruction from memory into the instruction register (IR) and decodes the IR fields.
- Drives every datapath control strobe, plus the program counter (PC), address-register and memory-command signals, to execute one instruction at a time.
- Sits between the top-level CPU wrapper (IR, PC, address registers, memory) and the datapath.

Parameters:
MEM_WAIT, 0, extra wait cycles per memory read (0..7); a read state is held for 1+MEM_WAIT cycles.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
ir  input  16  IR contents; fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0]
readnum  output  3  register-file read index
writenum  output  3  register-file write index
write  output  1  register-file write enable
vsel  output  2  write-back select: 00 mdata, 01 sximm8, 10 PC, 11 C
loada  output  1  A-register load
loadb  output  1  B-register load
asel  output  1  1 forces Ain=0
bsel  output  1  1 selects sximm5 as Bin
shift  output  2  shifter control
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
loadc  output  1  C-register load
loads  output  1  status-register load
load_ir  output  1  IR load from mdata
load_pc  output  1  PC load
reset_pc  output  1  1 makes next PC 0, else PC+1
addr_sel  output  1  memory address source: 1 PC, 0 address register
load_addr  output  1  address register loads C[8:0]
mem_cmd  output  2  00 none, 01 read, 10 write
halted  output  1  high in HALT state
bad_instr  output  1  sticky; set on undefined opcode

Behaviour:
- All outputs are a decode of the registered state only, plus ir fields and the wait counter. No output depends combinationally on reset_n other than through the state.
- Outputs not listed for a state are 0. readnum/writenum are 0 unless listed.
- reset_n low → state RST and wait counter 0, immediately (asynchronous). bad_instr clears.
- Reset asserted mid-instruction aborts the instruction; no strobe persists after reset_n goes low.
- Per-state outputs and transitions:
  - RST: reset_pc=1, load_pc=1. Next: IF1.
  - IF1: addr_sel=1, mem_cmd=01. Held 1+MEM_WAIT cycles via the wait counter, then IF2.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1. Next: UPD_PC.
  - UPD_PC: load_pc=1 (PC+1). Next: DECODE.
  - DECODE: dispatch on {opcode,op}:
    - 11010 MOV imm → WR_IMM
    - 11000 MOV reg → GET_B
    - 10100 ADD, 10101 CMP, 10110 AND → GET_A
    - 10111 MVN → GET_B
    - 01100 LDR, 10000 STR → GET_A
    - 11100 HALT → HALT
    - any other code → HALT with bad_instr set
  - WR_IMM: writenum=Rn, vsel=01, write=1. Next: IF1.
  - GET_A: readnum=Rn, loada=1. Next: GET_B for ALU ops; ADDR for LDR/STR.
  - GET_B: readnum=Rm, loadb=1. Next: EXEC.
  - EXEC: bsel=0, shift=sh, loadc=1, except CMP which uses loads=1 and loadc=0.
    - MOV reg: asel=1, ALUop=00.
    - Other ops: asel=0, ALUop=op.
    - Next: IF1 for CMP; WB otherwise.
  - WB: writenum=Rd, vsel=11, write=1. Next: IF1.
  - ADDR: asel=0, bsel=1, ALUop=00, loadc=1. Next: LD_ADDR.
  - LD_ADDR: load_addr=1. Next: MEM_RD for LDR; ST_GETB for STR.
  - MEM_RD: addr_sel=0, mem_cmd=01. Held 1+MEM_WAIT cycles, then LDR_WB.
  - LDR_WB: addr_sel=0, mem_cmd=01, writenum=Rd, vsel=00, write=1. Next: IF1.
  - ST_GETB: readnum=Rd, loadb=1. Next: ST_PASS.
  - ST_PASS: asel=1, bsel=0, shift=00, ALUop=00, loadc=1. Next: MEM_WR.
  - MEM_WR: addr_sel=0, mem_cmd=10. Next: IF1.
  - HALT: halted=1, all strobes 0. Exit only via reset.
- Wait counter:
  - Loads 0 on entry to IF1/MEM_RD.
  - Increments while in those states and the state advances when it equals MEM_WAIT.
  - Width is ceil(log2(MEM_WAIT+1)), minimum 1 bit.
- Latency, counted from the first IF1 cycle with MEM_WAIT=0: MOV imm 5, MOV reg/MVN 7, CMP 7, ADD/AND 8, LDR 9, STR 10.
  - Each read state adds MEM_WAIT cycles: one read for most instructions, two for LDR.
- ir is sampled only in states after IF2. ir changing during DECODE/execute is illegal because IR holds it.
- Never assert write and mem_cmd=10 in the same cycle. mem_cmd is never 11.

Test Plan:
- Reset: reset_n low mid-EXEC of ADD → within the same cycle loadc=0 and state=RST. After release: one cycle with reset_pc=1 and load_pc=1, then IF1 with mem_cmd=01 and addr_sel=1.
- MOV R3,#5 (ir=16'hD305), MEM_WAIT=0 → DECODE then WR_IMM with writenum=3, vsel=01, write=1. Total 5 cycles from IF1 to the next IF1.
- ADD R2,R1,R0,LSL#1 (ir=16'hA148) → GET_A readnum=1; GET_B readnum=0; EXEC shift=01, ALUop=00, loadc=1; WB writenum=2, vsel=11. 8 cycles.
- CMP R1,R0 (ir=16'hA900) → EXEC loads=1, loadc=0; no write cycle; returns to IF1 after 7 cycles.
- LDR R4,[R1,#2] (ir=16'h6182) with MEM_WAIT=2 → IF1 and MEM_RD each last 3 cycles. LDR_WB writenum=4, vsel=00, write=1. 13 cycles total. STR R4,[R1,#2] (ir=16'h8182) → MEM_WR with mem_cmd=10 and write=0 throughout the instruction.
- HALT (ir=16'hE000) → halted=1 held for ≥20 cycles, all strobes 0. Undefined ir=16'h0000 → HALT with bad_instr=1, cleared only by reset_n low.
